// File: rtl/cv32e40p_compressed_encoder.sv
// RV32 -> RVC compressor: replaces compressible instructions with their 16-bit form
// and packs the resulting 16/32-bit parcels into little-endian 32-bit words.
module cv32e40p_compressed_encoder #(
    parameter bit FPU = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [31:0] in_instr_i,
    input  logic        flush_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] out_word_o,
    output logic        empty_o,
    output logic [31:0] compressed_cnt_o
);
    localparam int unsigned ILEN = 32;
    localparam int unsigned CLEN = 16;

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_LOAD_FP  = 7'b0000111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_STORE_FP = 7'b0100111;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;

    logic [6:0]  opc, f7;
    logic [2:0]  f3;
    logic [4:0]  rd, rs1, rs2;
    logic [11:0] imm_i, imm_s;
    logic [20:1] imm_j;
    logic [12:1] imm_b;
    logic        rd_p, rs1_p, rs2_p, imm_i6;

    assign opc    = in_instr_i[6:0];
    assign rd     = in_instr_i[11:7];
    assign f3     = in_instr_i[14:12];
    assign rs1    = in_instr_i[19:15];
    assign rs2    = in_instr_i[24:20];
    assign f7     = in_instr_i[31:25];
    assign imm_i  = in_instr_i[31:20];
    assign imm_s  = {in_instr_i[31:25], in_instr_i[11:7]};
    assign imm_j  = {in_instr_i[31], in_instr_i[19:12], in_instr_i[20], in_instr_i[30:21]};
    assign imm_b  = {in_instr_i[31], in_instr_i[7], in_instr_i[30:25], in_instr_i[11:8]};
    assign rd_p   = (rd[4:3] == 2'b01);
    assign rs1_p  = (rs1[4:3] == 2'b01);
    assign rs2_p  = (rs2[4:3] == 2'b01);
    assign imm_i6 = (imm_i[11:5] == {7{imm_i[5]}});

    logic            c_hit;
    logic [CLEN-1:0] c_parcel;

    // Compression rules in priority order; first match wins.
    always_comb begin
        c_hit    = 1'b1;
        c_parcel = '0;
        if (in_instr_i == 32'h0000_0013) begin
            c_parcel = 16'h0001;
        end else if (opc == OPC_OP_IMM && f3 == 3'b000 && rs1 == 5'd0 && rd != 5'd0 && imm_i6) begin
            c_parcel = {3'b010, imm_i[5], rd, imm_i[4:0], 2'b01};
        end else if (opc == OPC_OP_IMM && f3 == 3'b000 && rd == 5'd2 && rs1 == 5'd2 &&
                     imm_i[3:0] == 4'd0 && imm_i != 12'd0 && imm_i[11:9] == {3{imm_i[9]}}) begin
            c_parcel = {3'b011, imm_i[9], 5'd2, imm_i[4], imm_i[6], imm_i[8:7], imm_i[5], 2'b01};
        end else if (opc == OPC_OP_IMM && f3 == 3'b000 && rd == rs1 && rd != 5'd0 &&
                     imm_i != 12'd0 && imm_i6) begin
            c_parcel = {3'b000, imm_i[5], rd, imm_i[4:0], 2'b01};
        end else if (opc == OPC_OP_IMM && f3 == 3'b000 && rd_p && rs1 == 5'd2 &&
                     imm_i[1:0] == 2'b00 && imm_i != 12'd0 && imm_i[11:10] == 2'b00) begin
            c_parcel = {3'b000, imm_i[5:4], imm_i[9:6], imm_i[2], imm_i[3], rd[2:0], 2'b00};
        end else if (opc == OPC_LUI && rd != 5'd0 && rd != 5'd2 &&
                     in_instr_i[31:17] == {15{in_instr_i[17]}} && in_instr_i[17:12] != 6'd0) begin
            c_parcel = {3'b011, in_instr_i[17], rd, in_instr_i[16:12], 2'b01};
        end else if (opc == OPC_OP_IMM && f3 == 3'b001 && f7 == 7'd0 && rd == rs1 &&
                     rd != 5'd0 && rs2 != 5'd0) begin
            c_parcel = {3'b000, 1'b0, rd, rs2, 2'b01 ^ 2'b11};
        end else if (opc == OPC_OP_IMM && f3 == 3'b101 && (f7 == 7'd0 || f7 == 7'b0100000) &&
                     rd == rs1 && rd_p && rs2 != 5'd0) begin
            c_parcel = {3'b100, 1'b0, 1'b0, f7[5], rd[2:0], rs2, 2'b01};
        end else if (opc == OPC_OP_IMM && f3 == 3'b111 && rd == rs1 && rd_p && imm_i6) begin
            c_parcel = {3'b100, imm_i[5], 2'b10, rd[2:0], imm_i[4:0], 2'b01};
        end else if (opc == OPC_OP && rd == rs1 && rd_p && rs2_p &&
                     ((f7 == 7'b0100000 && f3 == 3'b000) ||
                      (f7 == 7'd0 && (f3 == 3'b100 || f3 == 3'b110 || f3 == 3'b111)))) begin
            c_parcel = {3'b100, 1'b0, 2'b11, rd[2:0],
                        (f3 == 3'b000) ? 2'b00 : (f3 == 3'b100) ? 2'b01 : f3[1:0], rs2[2:0], 2'b01};
        end else if (opc == OPC_OP && f3 == 3'b000 && f7 == 7'd0 && rs1 == 5'd0 &&
                     rd != 5'd0 && rs2 != 5'd0) begin
            c_parcel = {3'b100, 1'b0, rd, rs2, 2'b10};
        end else if (opc == OPC_OP && f3 == 3'b000 && f7 == 7'd0 && rs1 == rd &&
                     rd != 5'd0 && rs2 != 5'd0) begin
            c_parcel = {3'b100, 1'b1, rd, rs2, 2'b10};
        end else if ((opc == OPC_LOAD || (FPU && opc == OPC_LOAD_FP)) && f3 == 3'b010 && rd_p && rs1_p &&
                     imm_i[11:7] == 5'd0 && imm_i[1:0] == 2'b00) begin
            c_parcel = {opc[2] ? 3'b011 : 3'b010, imm_i[5:3], rs1[2:0], imm_i[2], imm_i[6], rd[2:0], 2'b00};
        end else if ((opc == OPC_STORE || (FPU && opc == OPC_STORE_FP)) && f3 == 3'b010 && rs1_p && rs2_p &&
                     imm_s[11:7] == 5'd0 && imm_s[1:0] == 2'b00) begin
            c_parcel = {opc[2] ? 3'b111 : 3'b110, imm_s[5:3], rs1[2:0], imm_s[2], imm_s[6], rs2[2:0], 2'b00};
        end else if ((opc == OPC_LOAD || (FPU && opc == OPC_LOAD_FP)) && f3 == 3'b010 && rs1 == 5'd2 &&
                     (rd != 5'd0 || opc == OPC_LOAD_FP) && imm_i[11:8] == 4'd0 && imm_i[1:0] == 2'b00) begin
            c_parcel = {opc[2] ? 3'b011 : 3'b010, imm_i[5], rd, imm_i[4:2], imm_i[7:6], 2'b10};
        end else if ((opc == OPC_STORE || (FPU && opc == OPC_STORE_FP)) && f3 == 3'b010 && rs1 == 5'd2 &&
                     imm_s[11:8] == 4'd0 && imm_s[1:0] == 2'b00) begin
            c_parcel = {opc[2] ? 3'b111 : 3'b110, imm_s[5:2], imm_s[7:6], rs2, 2'b10};
        end else if (opc == OPC_JAL && rd[4:1] == 4'd0 && imm_j[20:11] == {10{imm_j[11]}}) begin
            c_parcel = {(rd == 5'd0) ? 3'b101 : 3'b001, imm_j[11], imm_j[4], imm_j[9:8], imm_j[10],
                        imm_j[6], imm_j[7], imm_j[3:1], imm_j[5], 2'b01};
        end else if (opc == OPC_JALR && f3 == 3'b000 && imm_i == 12'd0 && rs1 != 5'd0 && rd[4:1] == 4'd0) begin
            c_parcel = {3'b100, rd[0], rs1, 5'd0, 2'b10};
        end else if (opc == OPC_BRANCH && f3[2:1] == 2'b00 && rs1_p && rs2 == 5'd0 &&
                     imm_b[12:8] == {5{imm_b[8]}}) begin
            c_parcel = {2'b11, f3[0], imm_b[8], imm_b[4:3], rs1[2:0], imm_b[7:6], imm_b[2:1], imm_b[5], 2'b01};
        end else if (in_instr_i == 32'h0010_0073) begin
            c_parcel = 16'h9002;
        end else if (FPU && opc == OPC_LOAD_FP && f3 == 3'b011 && rd_p && rs1_p &&
                     imm_i[11:8] == 4'd0 && imm_i[2:0] == 3'd0) begin
            c_parcel = {3'b001, imm_i[5:3], rs1[2:0], imm_i[7:6], rd[2:0], 2'b00};
        end else if (FPU && opc == OPC_STORE_FP && f3 == 3'b011 && rs1_p && rs2_p &&
                     imm_s[11:8] == 4'd0 && imm_s[2:0] == 3'd0) begin
            c_parcel = {3'b101, imm_s[5:3], rs1[2:0], imm_s[7:6], rs2[2:0], 2'b00};
        end else if (FPU && opc == OPC_LOAD_FP && f3 == 3'b011 && rs1 == 5'd2 &&
                     imm_i[11:9] == 3'd0 && imm_i[2:0] == 3'd0) begin
            c_parcel = {3'b001, imm_i[5], rd, imm_i[4:3], imm_i[8:6], 2'b10};
        end else if (FPU && opc == OPC_STORE_FP && f3 == 3'b011 && rs1 == 5'd2 &&
                     imm_s[11:9] == 3'd0 && imm_s[2:0] == 3'd0) begin
            c_parcel = {3'b101, imm_s[5:3], imm_s[8:6], rs2, 2'b10};
        end else begin
            c_hit = 1'b0;
        end
    end

    logic            raw16, is16, accept, flush_fire, count_inc;
    logic [CLEN-1:0] parcel16;
    logic            res_valid_q, res_valid_d, out_valid_q, out_valid_d;
    logic [CLEN-1:0] res_q, res_d;
    logic [ILEN-1:0] out_word_q, out_word_d, cnt_q, cnt_d;

    assign raw16      = (in_instr_i[1:0] != 2'b11);
    assign is16       = raw16 || c_hit;
    assign parcel16   = raw16 ? in_instr_i[15:0] : c_parcel;
    assign in_ready_o = !out_valid_q || out_ready_i;
    assign accept     = in_valid_i && in_ready_o;
    assign flush_fire = flush_i && !in_valid_i && in_ready_o && res_valid_q;
    assign count_inc  = accept && !raw16 && c_hit && (cnt_q != '1);

    // Packing next-state: residue halfword plus a single output slot.
    always_comb begin
        res_valid_d = res_valid_q;
        res_d       = res_q;
        out_valid_d = out_valid_q && !out_ready_i;
        out_word_d  = out_word_q;
        cnt_d       = count_inc ? cnt_q + ILEN'(1) : cnt_q;
        if (accept) begin
            if (!res_valid_q) begin
                if (is16) begin
                    res_valid_d = 1'b1;
                    res_d       = parcel16;
                end else begin
                    out_valid_d = 1'b1;
                    out_word_d  = in_instr_i;
                end
            end else begin
                out_valid_d = 1'b1;
                if (is16) begin
                    out_word_d  = {parcel16, res_q};
                    res_valid_d = 1'b0;
                end else begin
                    out_word_d  = {in_instr_i[15:0], res_q};
                    res_d       = in_instr_i[31:16];
                end
            end
        end else if (flush_fire) begin
            out_valid_d = 1'b1;
            out_word_d  = {16'h0001, res_q};
            res_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid_q <= 1'b0;
            res_q       <= '0;
            out_valid_q <= 1'b0;
            out_word_q  <= '0;
            cnt_q       <= '0;
        end else begin
            res_valid_q <= res_valid_d;
            res_q       <= res_d;
            out_valid_q <= out_valid_d;
            out_word_q  <= out_word_d;
            cnt_q       <= cnt_d;
        end
    end

    assign out_valid_o      = out_valid_q;
    assign out_word_o       = out_word_q;
    assign empty_o          = !res_valid_q && !out_valid_q;
    assign compressed_cnt_o = cnt_q;
endmodule

// File: doc/cv32e40p_compressed_encoder.md
Name: cv32e40p_compressed_encoder

Overview:
- Inverse of the RVC expander. Takes a stream of RV32 instructions, replaces each one that has an exact RVC equivalent with its 16-bit form, and packs the resulting 16/32-bit parcels into little-endian 32-bit words.
- Sits in front of instruction-memory writers (code loaders, debug program buffer fill) so stored code is dense.
- Round-trip property: expanding any emitted compressed parcel reproduces the input instruction bit-exactly.

Parameters:
- FPU, 0, 1 enables compression of flw/fsw/fld/fsd (prime and x2-relative forms); 0 never produces them.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid_i  in  1  input instruction valid
- in_ready_o  out  1  input accepted when in_valid_i && in_ready_o
- in_instr_i  in  32  input instruction
- flush_i  in  1  request to emit pending residue halfword
- out_valid_o  out  1  packed word valid
- out_ready_i  in  1  consumer accepts word
- out_word_o  out  32  packed word; bits [15:0] hold the earlier parcel
- empty_o  out  1  no residue and no pending output word
- compressed_cnt_o  out  32  count of instructions compressed; saturates at 0xFFFFFFFF

Behaviour:
- Reset (async, rst_n=0):
  - out_valid_o=0, out_word_o=0, residue cleared, compressed_cnt_o=0.
  - in_ready_o=1 and empty_o=1 after reset release.
- Ready: in_ready_o = !out_valid_o || out_ready_i. Output register is a single slot; refill in the same cycle it drains is allowed.
- Parcel selection (combinational on in_instr_i):
  - If in_instr_i[1:0] != 2'b11, the parcel is in_instr_i[15:0] (16-bit, already compressed); this is not counted.
  - Otherwise the compression rules below apply; an instruction matching no rule is emitted as a 32-bit parcel.
- Compression rules. x' means x8..x15. Rules are checked in this priority order; the first match wins:
  - addi x0,x0,0 -> c.nop
  - addi rd,x0,imm, rd!=0, imm in [-32,31] -> c.li
  - addi x2,x2,imm, imm%16=0, imm!=0, imm in [-512,496] -> c.addi16sp
  - addi rd,rd,imm, rd!=0, imm!=0, imm in [-32,31] -> c.addi
  - addi rd',x2,imm, imm%4=0, imm in [4,1020] -> c.addi4spn
  - lui rd,imm, rd not in {0,2}, imm[31:17] is the sign-extension of imm[17], imm[17:12]!=0 -> c.lui
  - slli rd,rd,sh, rd!=0, sh!=0 -> c.slli
  - srli/srai rd',rd',sh, sh!=0 -> c.srli/c.srai
  - andi rd',rd',imm, imm in [-32,31] -> c.andi
  - sub/xor/or/and rd',rd',rs2' -> c.sub/c.xor/c.or/c.and
  - add rd,x0,rs2, rd!=0, rs2!=0 -> c.mv
  - add rd,rd,rs2, rd!=0, rs2!=0 -> c.add
  - lw/sw rd'|rs2', off(rs1'), off%4=0, off in [0,124] -> c.lw/c.sw
  - lw rd!=0, off(x2), off%4=0, off in [0,252] -> c.lwsp
  - sw rs2, off(x2), off%4=0, off in [0,252] -> c.swsp
  - jal x0|x1, off in [-2048,2046] -> c.j/c.jal
  - jalr x0,rs1!=0,0 -> c.jr
  - jalr x1,rs1!=0,0 -> c.jalr
  - beq/bne rs1',x0,off in [-256,254] -> c.beqz/c.bnez
  - ebreak -> c.ebreak
  - FPU=1 only: flw/fsw with the same ranges as lw/sw; fld/fsd with off%8=0 in [0,248] (prime form) or [0,504] (x2 form).
- Packing state is a residue flag plus a 16-bit residue register. On accept:
  - No residue, 16-bit parcel: store it as residue; no output.
  - No residue, 32-bit parcel: output word = instr.
  - Residue, 16-bit parcel c: output word = {c, residue}; residue cleared.
  - Residue, 32-bit parcel: output word = {instr[15:0], residue}; residue = instr[31:16].
- Latency: out_valid_o rises the cycle after the accepting edge. Words hold stable while out_valid_o && !out_ready_i.
- Flush:
  - flush_i is honoured only when in_valid_i=0 and in_ready_o=1.
  - With a residue: output word = {16'h0001, residue} and the residue is cleared.
  - Without a residue: no effect.
  - When flush_i is asserted together with in_valid_i, flush_i is ignored that cycle; the requester holds it.
- empty_o = !residue_valid && !out_valid_o.
- compressed_cnt_o increments by 1 for each accepted instruction that is converted to RVC.

Test Plan:
- Accept 0x00140413 (addi x8,x8,1) twice -> one word 0x04050405 one cycle after the 2nd accept; compressed_cnt_o=2; empty_o=1 after the word is consumed.
- Accept 0x00442483 (lw x9,4(x8)), then flush -> word 0x00014044.
- Accept 0x00140413, then 0x123452B7 (lui x5,0x12345, not compressible) -> word 0x52B70405, residue 0x1234; flush -> word 0x00011234.
- Boundary: 0x02040413 (addi x8,x8,32) -> 32-bit passthrough, count unchanged; 0xFE040413 (addi x8,x8,-32) -> parcel 0x1401.
- Backpressure: hold out_ready_i=0 with out_valid_o=1 -> in_ready_o=0 and out_word_o stable for 10 cycles; release -> same-cycle refill is accepted.
- Async reset while residue and output word are pending -> out_valid_o=0 immediately, residue lost, empty_o=1; the next flush produces no word.
